user_nmi_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream native memory interface (NMI: valid/ready/addr/wdata/wstrb/rdata) between NUM_MST requesting cores.
- Sits between several user cores (or a core plus a debug/DMA master) and the single NMI port a user-core slot exposes to the SoC.
- Adds a per-transaction timeout so a hung slave cannot deadlock the requesters.

---
 rtl/user_nmi_arb_pkg.sv | 20 ++
 rtl/nmi_if.sv | 12 +
 rtl/user_nmi_rr_pick.sv | 48 ++++
 rtl/user_nmi_arbiter.sv | 141 ++++++++++++++
 tb/tb_user_nmi_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/user_nmi_arb_pkg.sv
// Shared types and sizing helpers for the user-core NMI round-robin arbiter.
package user_nmi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Index width stays at least one bit so a single-master build still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/nmi_if.sv
// Native memory interface bundle: one request channel with a single ready strobe.
interface nmi_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/user_nmi_rr_pick.sv
// Combinational round-robin picker: first request strictly after the last
// granted index, wrapping, found by priority-encoding a doubled request vector.
module user_nmi_rr_pick
    import user_nmi_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    localparam int IW = idx_w(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_MST-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [2*NUM_MST-1:0] dbl;
    logic                 found;

    // Lower copy only keeps requests above the last winner; upper copy handles the wrap.
    always_comb begin
        dbl = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            dbl[i]           = req[i] && (i > int'(last));
            dbl[NUM_MST + i] = req[i];
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < 2 * NUM_MST; j++) begin
            if (!found && dbl[j]) begin
                found = 1'b1;
                idx   = (j >= NUM_MST) ? IW'(j - NUM_MST) : IW'(j);
            end
        end
    end

    assign any = |req;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            grant[i] = any && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/user_nmi_arbiter.sv
// Round-robin arbiter sharing one NMI port between NUM_MST masters, with a
// per-transaction timeout so a hung slave cannot deadlock the requesters.
//   state | meaning
//   IDLE  | no grant held; picker result is registered on any request
//   BUSY  | granted master drives the NMI until ready, timeout or drop of valid
module user_nmi_arbiter
    import user_nmi_arb_pkg::*;
#(
    parameter int          NUM_MST     = 2,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_MST-1:0]     mst_valid_i,
    output logic [NUM_MST-1:0]     mst_ready_o,
    input  logic [NUM_MST*32-1:0]  mst_addr_i,
    input  logic [NUM_MST*32-1:0]  mst_wdata_i,
    input  logic [NUM_MST*4-1:0]   mst_wstrb_i,
    output logic [31:0]            mst_rdata_o,
    nmi_if.master                  nmi,
    output logic [NUM_MST-1:0]     grant_o,
    output logic                   timeout_o
);

    localparam int            IW      = idx_w(NUM_MST);
    localparam int            CW      = cnt_w(TIMEOUT_CYC);
    localparam bit            TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] TC_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

    arb_state_t         state, state_nx;
    logic [NUM_MST-1:0] grant_nx;
    logic [IW-1:0]      idx, idx_nx;
    logic [IW-1:0]      last, last_nx;
    logic [CW-1:0]      cnt, cnt_nx;

    logic [NUM_MST-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               sel_valid;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_wstrb;
    logic               nmi_valid;
    logic               tc;

    user_nmi_rr_pick #(.NUM_MST(NUM_MST)) u_pick (
        .req   (mst_valid_i),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int m = 0; m < NUM_MST; m++) begin
            if (idx == IW'(m)) begin
                sel_valid = mst_valid_i[m];
                sel_addr  = mst_addr_i[32*m +: 32];
                sel_wdata = mst_wdata_i[32*m +: 32];
                sel_wstrb = mst_wstrb_i[4*m +: 4];
            end
        end
    end

    assign nmi.valid = nmi_valid;
    assign nmi.addr  = sel_addr;
    assign nmi.wdata = sel_wdata;
    assign nmi.wstrb = sel_wstrb;

    // Priority in BUSY: dropped valid aborts, then ready, then terminal count.
    always_comb begin
        state_nx    = state;
        grant_nx    = grant_o;
        idx_nx      = idx;
        last_nx     = last;
        cnt_nx      = '0;
        nmi_valid   = 1'b0;
        mst_ready_o = '0;
        mst_rdata_o = nmi.rdata;
        timeout_o   = 1'b0;
        tc          = TO_EN && (cnt == TC_LAST);
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = BUSY;
                    grant_nx = pick_grant;
                    idx_nx   = pick_idx;
                end
            end
            BUSY: begin
                if (!sel_valid) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end else if (nmi.ready) begin
                    nmi_valid   = 1'b1;
                    mst_ready_o = grant_o;
                    last_nx     = idx;
                    state_nx    = IDLE;
                    grant_nx    = '0;
                end else if (tc) begin
                    mst_ready_o = grant_o;
                    mst_rdata_o = ERR_RDATA;
                    timeout_o   = 1'b1;
                    last_nx     = idx;
                    state_nx    = IDLE;
                    grant_nx    = '0;
                end else begin
                    nmi_valid = 1'b1;
                    cnt_nx    = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            grant_o <= '0;
            idx     <= '0;
            last    <= IW'(NUM_MST - 1);
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            grant_o <= grant_nx;
            idx     <= idx_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_user_nmi_arbiter.sv
// Directed bench: a 2-master/16-cycle-timeout arbiter and a 4-master/8-cycle one.
module tb_user_nmi_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;

    logic [1:0]  a_valid, a_ready, a_grant;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_wstrb;
    logic [31:0] a_rdata;
    logic        a_timeout;

    logic [3:0]   b_valid, b_ready, b_grant;
    logic [127:0] b_addr, b_wdata;
    logic [15:0]  b_wstrb;
    logic [31:0]  b_rdata;
    logic         b_timeout;

    nmi_if nmi_a ();
    nmi_if nmi_b ();

    user_nmi_arbiter #(.NUM_MST(2), .TIMEOUT_CYC(16)) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_a_n),
        .mst_valid_i (a_valid),
        .mst_ready_o (a_ready),
        .mst_addr_i  (a_addr),
        .mst_wdata_i (a_wdata),
        .mst_wstrb_i (a_wstrb),
        .mst_rdata_o (a_rdata),
        .nmi         (nmi_a),
        .grant_o     (a_grant),
        .timeout_o   (a_timeout)
    );

    user_nmi_arbiter #(.NUM_MST(4), .TIMEOUT_CYC(8)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_b_n),
        .mst_valid_i (b_valid),
        .mst_ready_o (b_ready),
        .mst_addr_i  (b_addr),
        .mst_wdata_i (b_wdata),
        .mst_wstrb_i (b_wstrb),
        .mst_rdata_o (b_rdata),
        .nmi         (nmi_b),
        .grant_o     (b_grant),
        .timeout_o   (b_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic early;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_valid = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        nmi_a.ready = 1'b0; nmi_a.rdata = '0;
        nmi_b.ready = 1'b0; nmi_b.rdata = '0;
        #12;
        check_eq("rst_grant",   32'(a_grant),     32'h0);
        check_eq("rst_ready",   32'(a_ready),     32'h0);
        check_eq("rst_timeout", 32'(a_timeout),   32'h0);
        check_eq("rst_valid",   32'(nmi_a.valid), 32'h0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick;

        // single read by m0, slave ready on the third busy cycle
        a_valid = 2'b01; a_addr[31:0] = 32'h1000_0000; a_wstrb[3:0] = 4'h0;
        #1;
        check_eq("rd_idle_grant", 32'(a_grant),     32'h0);
        check_eq("rd_idle_valid", 32'(nmi_a.valid), 32'h0);
        tick;
        check_eq("rd_grant",  32'(a_grant),     32'h1);
        check_eq("rd_valid",  32'(nmi_a.valid), 32'h1);
        check_eq("rd_addr",   nmi_a.addr,       32'h1000_0000);
        check_eq("rd_wstrb",  32'(nmi_a.wstrb), 32'h0);
        check_eq("rd_noready",32'(a_ready),     32'h0);
        tick;
        tick;
        nmi_a.ready = 1'b1; nmi_a.rdata = 32'h1234_5678;
        #1;
        check_eq("rd_ready",   32'(a_ready),   32'h1);
        check_eq("rd_rdata",   a_rdata,        32'h1234_5678);
        check_eq("rd_timeout", 32'(a_timeout), 32'h0);
        tick;
        a_valid = '0; nmi_a.ready = 1'b0;
        #1;
        check_eq("rd_end_grant", 32'(a_grant), 32'h0);
        check_eq("rd_end_ready", 32'(a_ready), 32'h0);

        // write by m1 passes straight through
        a_valid = 2'b10; a_addr[63:32] = 32'h0200_0010;
        a_wdata[63:32] = 32'hA5A5_0F0F; a_wstrb[7:4] = 4'b0011;
        tick;
        check_eq("wr_grant", 32'(a_grant),     32'h2);
        check_eq("wr_addr",  nmi_a.addr,       32'h0200_0010);
        check_eq("wr_wdata", nmi_a.wdata,      32'hA5A5_0F0F);
        check_eq("wr_wstrb", 32'(nmi_a.wstrb), 32'h3);
        nmi_a.ready = 1'b1; nmi_a.rdata = 32'h0;
        #1;
        check_eq("wr_ready", 32'(a_ready), 32'h2);
        tick;
        a_valid = '0; nmi_a.ready = 1'b0;

        // timeout: both request, m0 wins, slave never ready
        a_valid = 2'b11; a_addr[31:0] = 32'h3000_0000;
        tick;
        check_eq("to_grant", 32'(a_grant), 32'h1);
        early = 1'b0;
        repeat (15) begin
            if (a_ready != 2'b00 || a_timeout) early = 1'b1;
            tick;
        end
        check_eq("to_early",   32'(early),       32'h0);
        check_eq("to_ready",   32'(a_ready),     32'h1);
        check_eq("to_rdata",   a_rdata,          32'hDEAD_BEEF);
        check_eq("to_pulse",   32'(a_timeout),   32'h1);
        check_eq("to_nmi_vld", 32'(nmi_a.valid), 32'h0);
        a_valid = 2'b10;
        tick;
        check_eq("to_idle_pulse", 32'(a_timeout), 32'h0);
        check_eq("to_idle_grant", 32'(a_grant),   32'h0);
        tick;
        check_eq("to_next_grant", 32'(a_grant), 32'h2);
        nmi_a.ready = 1'b1;
        #1;
        check_eq("to_next_ready", 32'(a_ready), 32'h2);
        tick;
        a_valid = '0; nmi_a.ready = 1'b0;

        // quick m0 read leaves the pointer on m0
        a_valid = 2'b01;
        tick;
        nmi_a.ready = 1'b1; nmi_a.rdata = 32'h0000_0042;
        #1;
        check_eq("q_ready", 32'(a_ready), 32'h1);
        check_eq("q_rdata", a_rdata,      32'h0000_0042);
        tick;
        a_valid = '0; nmi_a.ready = 1'b0;

        // m1 drops valid mid-transaction: abort, no ready, m1 keeps priority
        a_valid = 2'b10;
        tick;
        check_eq("ab_grant", 32'(a_grant), 32'h2);
        a_valid = 2'b00;
        #1;
        check_eq("ab_noready", 32'(a_ready),     32'h0);
        check_eq("ab_novalid", 32'(nmi_a.valid), 32'h0);
        tick;
        check_eq("ab_idle", 32'(a_grant), 32'h0);
        a_valid = 2'b11;
        tick;
        check_eq("ab_regrant", 32'(a_grant), 32'h2);

        // reset while m1 is busy
        rst_a_n = 1'b0;
        #1;
        check_eq("rb_valid", 32'(nmi_a.valid), 32'h0);
        check_eq("rb_grant", 32'(a_grant),     32'h0);
        check_eq("rb_ready", 32'(a_ready),     32'h0);
        #1;
        rst_a_n = 1'b1;
        tick;
        check_eq("rb_m0_first", 32'(a_grant), 32'h1);
        nmi_a.ready = 1'b1;
        #1;
        check_eq("rb_m0_ready", 32'(a_ready), 32'h1);
        tick;
        a_valid = '0; nmi_a.ready = 1'b0;

        // four-way contention with a zero-wait slave
        b_valid = 4'hF; nmi_b.ready = 1'b1; nmi_b.rdata = 32'h5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            tick;
            check_eq($sformatf("ct_grant%0d", k), 32'(b_grant), 32'(1) << (k % 4));
            check_eq($sformatf("ct_ready%0d", k), 32'(b_ready), 32'(1) << (k % 4));
            tick;
            check_eq($sformatf("ct_gap%0d", k), 32'(b_grant), 32'h0);
        end
        b_valid = '0; nmi_b.ready = 1'b0;

        // ready lands exactly on the terminal-count cycle
        b_valid = 4'b0100; b_addr[95:64] = 32'h0400_0080;
        b_wdata[95:64] = 32'h0BAD_F00D; b_wstrb[11:8] = 4'b1111;
        tick;
        check_eq("tc_grant", 32'(b_grant),     32'h4);
        check_eq("tc_addr",  nmi_b.addr,       32'h0400_0080);
        check_eq("tc_wdata", nmi_b.wdata,      32'h0BAD_F00D);
        check_eq("tc_wstrb", 32'(nmi_b.wstrb), 32'hF);
        repeat (6) tick;
        check_eq("tc_cycle7", 32'(b_timeout), 32'h0);
        tick;
        check_eq("tc_cycle8", 32'(b_timeout), 32'h1);
        nmi_b.ready = 1'b1; nmi_b.rdata = 32'hCAFE_F00D;
        #1;
        check_eq("tc_ready",   32'(b_ready),   32'h4);
        check_eq("tc_rdata",   b_rdata,        32'hCAFE_F00D);
        check_eq("tc_timeout", 32'(b_timeout), 32'h0);
        tick;
        b_valid = '0; nmi_b.ready = 1'b0;
        #1;
        check_eq("tc_end", 32'(b_grant), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
